// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared sizes and arbitration priority encoding
package ram_fifo_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} prio_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: stream handshakes, RAM pins and status of the FIFO controller
interface ram_fifo_ctrl_if;
  import ram_fifo_ctrl_pkg::*;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic ram_write_enable;
  logic [DATA_W-1:0] ram_data_out;
  logic [ADDR_W:0] level;
  logic full;
  modport master (
    input in_data, in_valid, out_ready, ram_data_out,
    output in_ready, out_data, out_valid, ram_address, ram_data_in, ram_write_enable, level, full
  );
  modport slave (
    output in_data, in_valid, out_ready, ram_data_out,
    input in_ready, out_data, out_valid, ram_address, ram_data_in, ram_write_enable, level, full
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: byte FIFO over a single-port synchronous 64x8 RAM with fair read/write arbitration
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  ram_fifo_ctrl_if.master bus
);
  localparam int LW = ADDR_W + 1;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic rd_pend;
  prio_t prio;
  logic rd_elig, full, wr_grant, rd_grant, in_ready;
  // arbitration and RAM pin drive; a write wins unless a read is also eligible and it is the read's turn
  always_comb begin
    full = bus.level == LW'(DEPTH);
    rd_elig = bus.level != '0 && !rd_pend && (!bus.out_valid || bus.out_ready);
    in_ready = !rst && !full && !(rd_elig && prio == PRIO_RD);
    wr_grant = bus.in_valid && in_ready;
    rd_grant = !rst && rd_elig && !wr_grant;
    bus.full = full;
    bus.in_ready = in_ready;
    bus.ram_address = wr_grant ? wr_ptr : rd_ptr;
    bus.ram_data_in = wr_grant ? bus.in_data : '0;
    bus.ram_write_enable = wr_grant;
  end
  // pointers, occupancy, priority toggle and the output register fed one cycle after each read issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.level <= '0;
      rd_pend <= 1'b0;
      prio <= PRIO_WR;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_grant);
      rd_ptr <= rd_ptr + ADDR_W'(rd_grant);
      bus.level <= bus.level + LW'(wr_grant) - LW'(rd_grant);
      rd_pend <= rd_grant;
      if (bus.in_valid && rd_elig) prio <= prio == PRIO_WR ? PRIO_RD : PRIO_WR;
      if (rd_pend) begin
        bus.out_data <= bus.ram_data_out;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed checks of ram_fifo_ctrl against a behavioural RAM and a byte scoreboard
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  ram_fifo_ctrl_if bus();
  ram_fifo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q [$];
  logic [ADDR_W-1:0] wa = '0;
  bit wrapped = 1'b0;
  bit rnd_ready = 1'b0;
  int pops = 0;
  int last_we = 0;
  int last_lvl = 0;
  always #5 clk = ~clk;
  // synchronous single-port RAM model
  always_ff @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(output bit acc);
    logic [31:0] exp;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(1, 0));
    @(negedge clk);
    acc = 1'b0;
    last_we = int'(bus.ram_write_enable);
    last_lvl = int'(bus.level);
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        chk("wr_addr", 32'(bus.ram_address), 32'(wa));
        chk("wr_data", 32'(bus.ram_data_in), 32'(bus.in_data));
        chk("wr_en", 32'(bus.ram_write_enable), 32'd1);
        q.push_back(bus.in_data);
        wa++;
        if (wa == '0) wrapped = 1'b1;
      end else begin
        chk("no_wr", 32'(bus.ram_write_enable), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = q.size() > 0 ? 32'(q.pop_front()) : 32'hxxxxxxxx;
        chk("out_data", 32'(bus.out_data), exp);
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    bit a;
    step(a);
  endtask
  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(acc);
      n++;
    end
    bus.in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask
  initial begin
    int lv [30];
    int wv [30];
    int rd_cnt, wr_cnt, run, max_run, prev, r, p0, acc_cnt;
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.ram_write_enable), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // write then drain with first-word latency
    send(8'h10);
    chk("lat_e0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_e1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_e2", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'h10);
    send(8'h11);
    send(8'hAF);
    chk("wd_level", 32'(bus.level), 32'd2);
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("wd_pops", 32'(pops), 32'd3);
    chk("wd_empty", 32'(q.size()), 32'd0);
    chk("wd_out_valid", 32'(bus.out_valid), 32'd0);
    // reset mid-stream
    bus.out_ready = 1'b0;
    send(8'h21);
    send(8'h22);
    send(8'h23);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h24;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    chk("mrst_level", 32'(bus.level), 32'd0);
    chk("mrst_full", 32'(bus.full), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mrst_we", 32'(bus.ram_write_enable), 32'd0);
    chk("mrst_addr", 32'(bus.ram_address), 32'd0);
    chk("mrst_din", 32'(bus.ram_data_in), 32'd0);
    bus.in_valid = 1'b0;
    q.delete();
    wa = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h5A);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("mrst_drain", 32'(q.size()), 32'd0);
    chk("mrst_out_valid2", 32'(bus.out_valid), 32'd0);
    // fill with 65 bytes while the consumer stalls
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i <= 64; i++) begin
      send(8'(i));
      acc_cnt++;
    end
    chk("fill_count", 32'(acc_cnt), 32'd65);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd64);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fill_out_data", 32'(bus.out_data), 32'h00);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h41;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("full_block", 32'(acc), 32'd0);
    end
    bus.in_valid = 1'b0;
    p0 = pops;
    bus.out_ready = 1'b1;
    repeat (160) tick();
    chk("fill_pops", 32'(pops - p0), 32'd65);
    chk("fill_drained", 32'(bus.level), 32'd0);
    // empty stall
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_valid", 32'(bus.out_valid), 32'd0);
      chk("empty_level", 32'(bus.level), 32'd0);
    end
    // wrap-around with random consumer
    wrapped = 1'b0;
    p0 = pops;
    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) send(8'(i));
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (160) tick();
    chk("wrap_pops", 32'(pops - p0), 32'd100);
    chk("wrap_empty", 32'(q.size()), 32'd0);
    chk("wrap_ptr", 32'(wrapped), 32'd1);
    // contested arbitration
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hC0;
    for (int i = 0; i < 30; i++) begin
      step(acc);
      lv[i] = last_lvl;
      wv[i] = last_we;
      if (acc) bus.in_data = bus.in_data + 8'd1;
    end
    bus.in_valid = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    run = 0;
    max_run = 0;
    prev = -1;
    for (int i = 3; i < 29; i++) begin
      r = lv[i] + wv[i] - lv[i + 1];
      chk("one_op", 32'(wv[i] + r), 32'd1);
      rd_cnt += r;
      wr_cnt += wv[i];
      run = wv[i] == prev ? run + 1 : 1;
      prev = wv[i];
      max_run = run > max_run ? run : max_run;
    end
    chk("arb_reads", 32'(rd_cnt >= 8), 32'd1);
    chk("arb_writes", 32'(wr_cnt >= 8), 32'd1);
    chk("arb_max_run", 32'(max_run <= 2), 32'd1);
    repeat (80) tick();
    chk("arb_drained", 32'(q.size()), 32'd0);
    chk("arb_level", 32'(bus.level), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
